// File: rtl/oflow_core_fsm_fe_dispatch_if.sv
// Signal bundle between the core top FSM / PE array and the feature-extraction set dispatcher.
interface oflow_core_fsm_fe_dispatch_if #(
    parameter int PE_NUM  = 24,
    parameter int SET_W   = 8,
    parameter int BBOX_W  = 11,
    parameter int FRAME_W = 16
);
    logic                start_pe;
    logic [SET_W-1:0]    num_of_sets;
    logic [BBOX_W-1:0]   remain_bboxes;
    logic                new_set;
    logic [FRAME_W-1:0]  frame_num;
    logic                done_registration;
    logic                done_score_calc;
    logic                abort;
    logic [PE_NUM-1:0]   done_fe_i;
    logic [PE_NUM-1:0]   start_fe_i;
    logic [PE_NUM-1:0]   active_mask;
    logic [SET_W-1:0]    counter_set_fe;
    logic                done_fe;
    logic                ready_new_set;
    logic                flg_sample_last_set;
    logic                frame_done;
    logic                busy;
    logic                timeout;
    logic [PE_NUM-1:0]   err_pe_mask;

    modport slave (
        input  start_pe, num_of_sets, remain_bboxes, new_set, frame_num,
               done_registration, done_score_calc, abort, done_fe_i,
        output start_fe_i, active_mask, counter_set_fe, done_fe, ready_new_set,
               flg_sample_last_set, frame_done, busy, timeout, err_pe_mask
    );

    modport master (
        output start_pe, num_of_sets, remain_bboxes, new_set, frame_num,
               done_registration, done_score_calc, abort, done_fe_i,
        input  start_fe_i, active_mask, counter_set_fe, done_fe, ready_new_set,
               flg_sample_last_set, frame_done, busy, timeout, err_pe_mask
    );
endinterface

// File: rtl/oflow_core_fsm_fe_dispatch.sv
// Splits a frame's bboxes into PE-sized sets, pulses per-PE starts and gathers per-PE dones.
// Optional hang watchdog in WAIT is enabled by defining OFLOW_FE_WATCHDOG_EN.
module oflow_core_fsm_fe_dispatch #(
    parameter int PE_NUM      = 24,
    parameter int SET_W       = 8,
    parameter int BBOX_W      = 11,
    parameter int FRAME_W     = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset_N,
    oflow_core_fsm_fe_dispatch_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_GATE} state_t;

    state_t             state, state_d;
    logic [SET_W-1:0]   num_sets_q, num_sets_d, counter_q, counter_d;
    logic [PE_NUM-1:0]  active_q, active_d, sticky_q, sticky_d, start_q, start_d, set_mask;
    logic               gate_q, gate_d, done_fe_q, done_fe_d, ready_q, ready_d;
    logic               flg_q, flg_d, frame_done_q, frame_done_d, busy_q;
    logic               gate_event, last_set;

    // Which downstream completion releases the next set depends on first frame vs later frames.
    assign gate_event = (bus.frame_num == '0) ? bus.done_registration : bus.done_score_calc;
    assign last_set   = (counter_q == (num_sets_q - SET_W'(1)));

    always_comb begin
        for (int i = 0; i < PE_NUM; i++)
            set_mask[i] = last_set ? (32'(bus.remain_bboxes) > 32'(i)) : 1'b1;
    end

`ifdef OFLOW_FE_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               timeout_q, timeout_d;
    logic [PE_NUM-1:0]  err_q, err_d;
`endif

    always_comb begin
        state_d      = state;
        num_sets_d   = num_sets_q;
        counter_d    = counter_q;
        active_d     = active_q;
        sticky_d     = sticky_q;
        gate_d       = gate_q;
        flg_d        = flg_q;
        start_d      = '0;
        done_fe_d    = 1'b0;
        ready_d      = 1'b0;
        frame_done_d = 1'b0;
`ifdef OFLOW_FE_WATCHDOG_EN
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
        err_d        = err_q;
`endif
        case (state)
            S_IDLE: begin
                counter_d = '0;
                if (bus.start_pe) begin
                    if (bus.num_of_sets != '0) begin
                        num_sets_d = bus.num_of_sets;
                        flg_d      = 1'b0;
                        state_d    = S_DISPATCH;
`ifdef OFLOW_FE_WATCHDOG_EN
                        timeout_d  = 1'b0;
                        err_d      = '0;
`endif
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            S_DISPATCH: begin
                if (counter_q == '0 || bus.new_set) begin
                    active_d = set_mask;
                    sticky_d = '0;
                    start_d  = set_mask;
                    gate_d   = 1'b0;
                    state_d  = S_WAIT;
`ifdef OFLOW_FE_WATCHDOG_EN
                    wdog_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                sticky_d = sticky_q | (bus.done_fe_i & active_q);
                gate_d   = gate_q | gate_event;
                if (sticky_d == active_q) begin
                    done_fe_d = 1'b1;
                    if (last_set) begin
                        frame_done_d = 1'b1;
                        flg_d        = 1'b1;
                        counter_d    = '0;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_GATE;
                    end
                end
`ifdef OFLOW_FE_WATCHDOG_EN
                else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    err_d     = active_q & ~sticky_d;
                    counter_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            S_GATE: begin
                gate_d = gate_q | gate_event;
                if (counter_q == '0 || gate_q || gate_event) begin
                    if (counter_q < (num_sets_q - SET_W'(1)))
                        counter_d = counter_q + SET_W'(1);
                    ready_d = (32'(bus.remain_bboxes) >= 32'(PE_NUM));
                    state_d = S_DISPATCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything decided above except the sticky watchdog error.
        if (bus.abort) begin
            state_d      = S_IDLE;
            counter_d    = '0;
            sticky_d     = '0;
            gate_d       = 1'b0;
            flg_d        = flg_q;
            start_d      = '0;
            done_fe_d    = 1'b0;
            ready_d      = 1'b0;
            frame_done_d = 1'b0;
`ifdef OFLOW_FE_WATCHDOG_EN
            timeout_d    = timeout_q;
            err_d        = err_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) state <= S_IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            num_sets_q   <= '0;
            counter_q    <= '0;
            active_q     <= '0;
            sticky_q     <= '0;
            start_q      <= '0;
            gate_q       <= 1'b0;
            done_fe_q    <= 1'b0;
            ready_q      <= 1'b0;
            flg_q        <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            num_sets_q   <= num_sets_d;
            counter_q    <= counter_d;
            active_q     <= active_d;
            sticky_q     <= sticky_d;
            start_q      <= start_d;
            gate_q       <= gate_d;
            done_fe_q    <= done_fe_d;
            ready_q      <= ready_d;
            flg_q        <= flg_d;
            frame_done_q <= frame_done_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

`ifdef OFLOW_FE_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            err_q     <= '0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end
    assign bus.timeout     = timeout_q;
    assign bus.err_pe_mask = err_q;
`else
    assign bus.timeout     = 1'b0;
    assign bus.err_pe_mask = '0;
`endif

    assign bus.start_fe_i          = start_q;
    assign bus.active_mask         = active_q;
    assign bus.counter_set_fe      = counter_q;
    assign bus.done_fe             = done_fe_q;
    assign bus.ready_new_set       = ready_q;
    assign bus.flg_sample_last_set = flg_q;
    assign bus.frame_done          = frame_done_q;
    assign bus.busy                = busy_q;
endmodule

// File: tb/tb_oflow_core_fsm_fe_dispatch.sv
// Directed bench for the FE set dispatcher: multi-set frame, gating, sticky done, abort, empty frame, watchdog.
module tb_oflow_core_fsm_fe_dispatch;
    localparam int PE_NUM      = 24;
    localparam int SET_W       = 8;
    localparam int BBOX_W      = 11;
    localparam int FRAME_W     = 16;
    localparam int WDOG_CYCLES = 16;
    localparam logic [PE_NUM-1:0] ALL  = 24'hFF_FFFF;
    localparam logic [PE_NUM-1:0] NONE = 24'h00_0000;

    logic clk = 1'b0;
    logic reset_N = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    oflow_core_fsm_fe_dispatch_if #(
        .PE_NUM(PE_NUM), .SET_W(SET_W), .BBOX_W(BBOX_W), .FRAME_W(FRAME_W)
    ) bus ();

    oflow_core_fsm_fe_dispatch #(
        .PE_NUM(PE_NUM), .SET_W(SET_W), .BBOX_W(BBOX_W), .FRAME_W(FRAME_W),
        .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs, then land just after the next rising edge.
    task automatic applyStimulus(input logic start, input logic nset, input logic dreg,
                                 input logic dscore, input logic abrt,
                                 input logic [PE_NUM-1:0] dones);
        bus.start_pe          = start;
        bus.new_set           = nset;
        bus.done_registration = dreg;
        bus.done_score_calc   = dscore;
        bus.abort             = abrt;
        bus.done_fe_i         = dones;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [PE_NUM-1:0] bit_v;
        bus.start_pe = 1'b0; bus.num_of_sets = '0; bus.remain_bboxes = '0;
        bus.new_set = 1'b0;  bus.frame_num = '0;   bus.done_registration = 1'b0;
        bus.done_score_calc = 1'b0; bus.abort = 1'b0; bus.done_fe_i = '0;

        quiet(2);
        checkOutput("rst_busy",     32'(bus.busy), 0);
        checkOutput("rst_start",    32'(bus.start_fe_i), 0);
        checkOutput("rst_active",   32'(bus.active_mask), 0);
        checkOutput("rst_counter",  32'(bus.counter_set_fe), 0);
        checkOutput("rst_done_fe",  32'(bus.done_fe), 0);
        checkOutput("rst_ready",    32'(bus.ready_new_set), 0);
        checkOutput("rst_flg",      32'(bus.flg_sample_last_set), 0);
        checkOutput("rst_frame",    32'(bus.frame_done), 0);
        checkOutput("rst_timeout",  32'(bus.timeout), 0);
        checkOutput("rst_err",      32'(bus.err_pe_mask), 0);
        reset_N = 1'b1;
        quiet(1);

        // Multi-set frame, later frame gated by score calc
        $display("[TB] multi-set frame");
        bus.frame_num = 16'd1; bus.num_of_sets = 8'd3; bus.remain_bboxes = 11'd53;
        applyStimulus(1, 0, 0, 0, 0, NONE);
        checkOutput("t1_busy", 32'(bus.busy), 1);
        checkOutput("t1_nostart_yet", 32'(bus.start_fe_i), 0);
        quiet(1);
        checkOutput("t1_set0_start", 32'(bus.start_fe_i), 32'(ALL));
        checkOutput("t1_set0_counter", 32'(bus.counter_set_fe), 0);
        applyStimulus(0, 0, 0, 0, 0, ALL);
        checkOutput("t1_set0_done_fe", 32'(bus.done_fe), 1);
        checkOutput("t1_start_is_pulse", 32'(bus.start_fe_i), 0);
        quiet(1);
        checkOutput("t1_counter1", 32'(bus.counter_set_fe), 1);
        checkOutput("t1_ready0", 32'(bus.ready_new_set), 1);
        checkOutput("t1_done_fe_pulse", 32'(bus.done_fe), 0);
        bus.remain_bboxes = 11'd29;
        applyStimulus(0, 1, 0, 0, 0, NONE);
        checkOutput("t1_set1_start", 32'(bus.start_fe_i), 32'(ALL));
        applyStimulus(0, 0, 0, 1, 0, ALL);
        checkOutput("t1_set1_done_fe", 32'(bus.done_fe), 1);
        quiet(1);
        checkOutput("t1_counter2", 32'(bus.counter_set_fe), 2);
        checkOutput("t1_ready1", 32'(bus.ready_new_set), 1);
        bus.remain_bboxes = 11'd5;
        applyStimulus(0, 1, 0, 0, 0, NONE);
        checkOutput("t1_set2_start", 32'(bus.start_fe_i), 32'h1F);
        checkOutput("t1_set2_active", 32'(bus.active_mask), 32'h1F);
        checkOutput("t1_set2_counter", 32'(bus.counter_set_fe), 2);
        applyStimulus(0, 0, 0, 0, 0, 24'h1F);
        checkOutput("t1_set2_done_fe", 32'(bus.done_fe), 1);
        checkOutput("t1_frame_done", 32'(bus.frame_done), 1);
        checkOutput("t1_flg", 32'(bus.flg_sample_last_set), 1);
        checkOutput("t1_idle", 32'(bus.busy), 0);
        checkOutput("t1_counter_idle", 32'(bus.counter_set_fe), 0);
        quiet(1);
        checkOutput("t1_frame_done_pulse", 32'(bus.frame_done), 0);
        checkOutput("t1_flg_held", 32'(bus.flg_sample_last_set), 1);

        // First frame: gated by registration, score calc ignored
        $display("[TB] gating and sticky done");
        bus.frame_num = 16'd0; bus.num_of_sets = 8'd4; bus.remain_bboxes = 11'd53;
        applyStimulus(1, 0, 0, 0, 0, NONE);
        checkOutput("t2_flg_cleared", 32'(bus.flg_sample_last_set), 0);
        quiet(1);
        checkOutput("t2_set0_start", 32'(bus.start_fe_i), 32'(ALL));
        applyStimulus(0, 0, 0, 0, 0, ALL);
        quiet(1);
        checkOutput("t2_counter1", 32'(bus.counter_set_fe), 1);
        bus.remain_bboxes = 11'd29;
        applyStimulus(0, 1, 0, 0, 0, NONE);
        checkOutput("t2_set1_start", 32'(bus.start_fe_i), 32'(ALL));
        applyStimulus(0, 0, 0, 0, 0, ALL);
        checkOutput("t2_set1_done_fe", 32'(bus.done_fe), 1);
        bus.remain_bboxes = 11'd40;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 1, 0, NONE);
            checkOutput("t2_gate_hold_start", 32'(bus.start_fe_i), 0);
            checkOutput("t2_gate_hold_counter", 32'(bus.counter_set_fe), 1);
        end
        applyStimulus(0, 1, 1, 0, 0, NONE);
        checkOutput("t2_release_counter", 32'(bus.counter_set_fe), 2);
        applyStimulus(0, 1, 0, 0, 0, NONE);
        checkOutput("t2_release_start", 32'(bus.start_fe_i), 32'(ALL));
        applyStimulus(0, 0, 1, 0, 0, NONE);
        checkOutput("t2_wait_no_done", 32'(bus.done_fe), 0);
        bus.remain_bboxes = 11'd5;
        applyStimulus(0, 0, 0, 0, 0, ALL);
        checkOutput("t2_set2_done_fe", 32'(bus.done_fe), 1);
        quiet(1);
        checkOutput("t2_wait_pulse_release", 32'(bus.counter_set_fe), 3);
        checkOutput("t2_ready_low_remain", 32'(bus.ready_new_set), 0);
        applyStimulus(0, 1, 0, 0, 0, NONE);
        checkOutput("t2_last_start", 32'(bus.start_fe_i), 32'h1F);
        for (int i = 0; i < 4; i++) begin
            bit_v = PE_NUM'(1) << i;
            applyStimulus(0, 0, 0, 0, 0, bit_v);
            checkOutput("t3_partial_no_done", 32'(bus.done_fe), 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 24'h80_0000);
        checkOutput("t3_stray_no_done", 32'(bus.done_fe), 0);
        applyStimulus(0, 0, 0, 0, 0, 24'h00_0010);
        checkOutput("t3_done_after_bit4", 32'(bus.done_fe), 1);
        checkOutput("t3_frame_done", 32'(bus.frame_done), 1);
        quiet(1);
        checkOutput("t3_done_fe_pulse", 32'(bus.done_fe), 0);
        checkOutput("t3_idle", 32'(bus.busy), 0);

        // Abort in WAIT of set 1, then restart
        $display("[TB] abort");
        bus.frame_num = 16'd1; bus.num_of_sets = 8'd3; bus.remain_bboxes = 11'd53;
        applyStimulus(1, 0, 0, 0, 0, NONE);
        quiet(1);
        applyStimulus(0, 0, 0, 0, 0, ALL);
        quiet(1);
        applyStimulus(0, 1, 0, 0, 0, NONE);
        checkOutput("t4_set1_start", 32'(bus.start_fe_i), 32'(ALL));
        applyStimulus(0, 0, 0, 0, 1, ALL);
        checkOutput("t4_abort_busy", 32'(bus.busy), 0);
        checkOutput("t4_abort_counter", 32'(bus.counter_set_fe), 0);
        checkOutput("t4_abort_no_done_fe", 32'(bus.done_fe), 0);
        checkOutput("t4_abort_no_frame", 32'(bus.frame_done), 0);
        quiet(1);
        checkOutput("t4_after_abort_idle", 32'(bus.busy), 0);
        checkOutput("t4_after_abort_no_done", 32'(bus.done_fe), 0);
        applyStimulus(1, 0, 0, 0, 0, NONE);
        checkOutput("t4_restart_busy", 32'(bus.busy), 1);
        quiet(1);
        checkOutput("t4_restart_start", 32'(bus.start_fe_i), 32'(ALL));
        checkOutput("t4_restart_counter", 32'(bus.counter_set_fe), 0);
        applyStimulus(0, 0, 0, 0, 1, NONE);
        checkOutput("t4_abort2_idle", 32'(bus.busy), 0);

        // Empty frame
        $display("[TB] empty frame");
        bus.num_of_sets = 8'd0;
        applyStimulus(1, 0, 0, 0, 0, NONE);
        checkOutput("t5_frame_done", 32'(bus.frame_done), 1);
        checkOutput("t5_busy", 32'(bus.busy), 0);
        checkOutput("t5_no_start", 32'(bus.start_fe_i), 0);
        quiet(1);
        checkOutput("t5_frame_done_pulse", 32'(bus.frame_done), 0);
        checkOutput("t5_no_start_later", 32'(bus.start_fe_i), 0);

        // PE 3 never finishes
        $display("[TB] hung PE");
        bus.num_of_sets = 8'd1; bus.remain_bboxes = 11'd5;
        applyStimulus(1, 0, 0, 0, 0, NONE);
        quiet(1);
        checkOutput("t6_start", 32'(bus.start_fe_i), 32'h1F);
`ifdef OFLOW_FE_WATCHDOG_EN
        for (int i = 0; i < WDOG_CYCLES - 1; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 24'h17);
            checkOutput("t6_no_timeout_yet", 32'(bus.timeout), 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 24'h17);
        checkOutput("t6_timeout", 32'(bus.timeout), 1);
        checkOutput("t6_err_mask", 32'(bus.err_pe_mask), 32'h8);
        checkOutput("t6_idle", 32'(bus.busy), 0);
        checkOutput("t6_no_frame_done", 32'(bus.frame_done), 0);
        checkOutput("t6_no_done_fe", 32'(bus.done_fe), 0);
        quiet(1);
        checkOutput("t6_timeout_sticky", 32'(bus.timeout), 1);
        applyStimulus(1, 0, 0, 0, 0, NONE);
        checkOutput("t6_timeout_cleared", 32'(bus.timeout), 0);
        checkOutput("t6_err_cleared", 32'(bus.err_pe_mask), 0);
`else
        for (int i = 0; i < WDOG_CYCLES + 4; i++) applyStimulus(0, 0, 0, 0, 0, 24'h17);
        checkOutput("t6_no_timeout", 32'(bus.timeout), 0);
        checkOutput("t6_no_err", 32'(bus.err_pe_mask), 0);
        checkOutput("t6_still_waiting", 32'(bus.busy), 1);
        checkOutput("t6_no_done_fe", 32'(bus.done_fe), 0);
`endif
        applyStimulus(0, 0, 0, 0, 1, NONE);
        checkOutput("t6_abort_idle", 32'(bus.busy), 0);
        quiet(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/oflow_core_fsm_fe_dispatch.md
Name: oflow_core_fsm_fe_dispatch

Overview:
Parametrised feature-extraction set dispatcher for the oflow core.
- Splits a frame's bboxes into sets of up to PE_NUM, issues per-PE start pulses and accumulates per-PE done.
- Gates each following set on downstream registration (first frame) or score calculation (later frames).
- Sits between the core top FSM and the PE array. Adds sticky done capture, abort, a frame-complete pulse and an optional hang watchdog.

Parameters:
PE_NUM, 24, number of processing elements (max bboxes per set)
SET_W, 8, width of set count/index
BBOX_W, 11, width of remaining-bbox counter
FRAME_W, 16, width of frame number
WDOG_CYCLES, 4096, watchdog limit in cycles (used only with the macro)

Ports:
clk  in  1  clock
reset_N  in  1  async active-low reset
start_pe  in  1  frame start request, sampled only in IDLE
num_of_sets  in  SET_W  sets in current frame, sampled at start
remain_bboxes  in  BBOX_W  bboxes not yet dispatched, including the current set
new_set  in  1  next set's data is loaded and valid
frame_num  in  FRAME_W  current frame index
done_registration  in  1  downstream registration done (level or pulse)
done_score_calc  in  1  downstream score calc done (level or pulse)
abort  in  1  synchronous abort of current frame
done_fe_i  in  PE_NUM  per-PE done (level or pulse)
start_fe_i  out  PE_NUM  per-PE start, one-cycle pulse
active_mask  out  PE_NUM  PEs used by current set
counter_set_fe  out  SET_W  index of current set
done_fe  out  1  one-cycle pulse when all active PEs are done
ready_new_set  out  1  one-cycle pulse requesting the next set load
flg_sample_last_set  out  1  high after the last set completes, until the next accepted start
frame_done  out  1  one-cycle pulse at frame completion
busy  out  1  high in any state except IDLE
timeout  out  1  sticky watchdog error
err_pe_mask  out  PE_NUM  PEs that failed to finish at timeout

Behaviour:
- Reset: state IDLE. All outputs are 0.
- States are IDLE, DISPATCH, WAIT and GATE. All outputs are registered.
- IDLE:
  - counter_set_fe is held at 0.
  - start_pe=1 and num_of_sets>0: go to DISPATCH and clear flg_sample_last_set.
  - start_pe=1 and num_of_sets=0: pulse frame_done in the next cycle, stay in IDLE, issue no start.
- DISPATCH: waits until counter_set_fe==0 or new_set=1, then computes the set mask.
  - Last set (counter_set_fe==num_of_sets-1): mask = low min(remain_bboxes, PE_NUM) bits set. remain_bboxes=0 gives an all-zero mask, which completes immediately.
  - Any other set: mask = all ones.
  - On issue: load active_mask, clear the sticky done vector, pulse start_fe_i=mask in the next cycle, go to WAIT.
- WAIT:
  - sticky |= done_fe_i & active_mask. Done bits outside active_mask are ignored.
  - A done arriving in the same cycle as start_fe_i counts.
  - When sticky==active_mask: pulse done_fe for one cycle.
    - Last set: go to IDLE, pulse frame_done and set flg_sample_last_set in the same cycle as done_fe.
    - Otherwise: go to GATE.
- Downstream-done capture: a sticky gate flag is cleared on entering WAIT. It is set by done_registration when frame_num==0, or by done_score_calc when frame_num!=0, in WAIT or GATE.
- GATE: releases when counter_set_fe==0 or the gate flag is set. On release:
  - counter_set_fe increments.
  - ready_new_set pulses in the next cycle if remain_bboxes>=PE_NUM.
  - Go to DISPATCH.
- counter_set_fe never exceeds num_of_sets-1. There is no wrap-around.
- abort (highest priority, any state):
  - Next cycle: IDLE, counter 0, sticky vectors cleared.
  - start_fe_i/done_fe/ready_new_set/frame_done are suppressed in that cycle.
  - timeout is unaffected.
- start_pe while busy is ignored.
- Inputs num_of_sets and frame_num are held stable by the top while busy.
- Latency:
  - start_pe high in IDLE to first start_fe_i pulse: 2 cycles when counter 0.
  - Last sticky bit to done_fe: 1 cycle.

Optional Feature:
OFLOW_FE_WATCHDOG_EN
- Defined:
  - A cycle counter resets on entering WAIT and counts while in WAIT.
  - On reaching WDOG_CYCLES: timeout is set (sticky until reset or the next accepted start_pe), err_pe_mask = active_mask & ~sticky, go to IDLE, no done_fe and no frame_done.
- Not defined: timeout and err_pe_mask are tied 0, no counter logic exists, and WAIT waits indefinitely.

Test Plan:
- Multi-set frame: PE_NUM=24, num_of_sets=3, remain_bboxes 53/29/5 at each set, frame_num=1, done_score_calc after each set → start_fe_i sequence 0xFFFFFF, 0xFFFFFF, 0x00001F; counter 0,1,2; three done_fe pulses; one frame_done; flg_sample_last_set=1.
- Gating: frame_num=0, set 1 all PEs done, done_registration held low 10 cycles → state stays GATE and no start pulse; done_registration pulses 1 cycle → start_fe_i=0xFFFFFF 2 cycles later. Pulse arriving during WAIT also releases.
- Sticky done: last set mask 0x00001F, done_fe_i pulses bit0..bit4 on separate cycles plus stray bit23 → done_fe exactly 1 cycle after bit4; bit23 has no effect.
- Abort: abort in WAIT of set 1 → busy=0 and counter=0 next cycle, no done_fe/frame_done; new start_pe then restarts at set 0.
- Empty frame: num_of_sets=0, start_pe → single frame_done pulse, start_fe_i stays 0.
- Watchdog (macro on, WDOG_CYCLES=16): PE 3 never asserts done → timeout=1 after 16 WAIT cycles, err_pe_mask=0x000008, state IDLE, no frame_done.
